// File: rtl/serial_word_collector.sv
// Serial-in, parallel-out word assembler: collects WORD_LENGTH bits MSB- or
// LSB-first and hands the finished word downstream over a valid/ready handshake.
module serial_word_collector #(
  parameter int unsigned WORD_LENGTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             serialInput,
  input  logic                             bitValid,
  input  logic                             LoR,
  input  logic                             wordReady,
  output logic [WORD_LENGTH-1:0]           parallelOutput,
  output logic                             wordValid,
  output logic                             busy,
  output logic [$clog2(WORD_LENGTH):0]     bitCount,
  output logic                             overflow
);

  localparam int unsigned W     = WORD_LENGTH;
  localparam int unsigned CNT_W = $clog2(WORD_LENGTH) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_LENGTH);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             dir_q,   dir_d;
  logic             ovf_q,   ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;

  // Register image of a word's first bit, placed at its entry position.
  logic [W-1:0] first_load;
  logic [W-1:0] shift_left;
  logic [W-1:0] shift_right;

  always_comb begin
    first_load = '0;
    if (LoR) begin
      first_load[W-1] = serialInput;
    end else begin
      first_load[0] = serialInput;
    end
    shift_left  = {shift_q[W-2:0], serialInput};
    shift_right = {serialInput, shift_q[W-1:1]};
  end

  // State register and all output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      shift_q <= '0;
      cnt_q   <= CNT_ZERO;
      dir_q   <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath update; clear overrides every other input.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = COLLECT;
      shift_d = '0;
      cnt_d   = CNT_ZERO;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (bitValid) begin
            if (cnt_q == CNT_ZERO) begin
              dir_d   = LoR;
              shift_d = first_load;
              cnt_d   = CNT_ONE;
            end else begin
              shift_d = dir_q ? shift_right : shift_left;
              cnt_d   = cnt_q + CNT_ONE;
              if (cnt_q == CNT_LAST) begin
                cnt_d   = CNT_FULL;
                state_d = FULL;
              end
            end
          end
        end
        FULL: begin
          if (wordReady) begin
            state_d = COLLECT;
            cnt_d   = CNT_ZERO;
            // Zero-bubble: a bit on the accepting edge starts the next word.
            if (bitValid) begin
              dir_d   = LoR;
              shift_d = first_load;
              cnt_d   = CNT_ONE;
            end
          end else if (bitValid) begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          state_d = COLLECT;
        end
      endcase
    end

    valid_d = (state_d == FULL);
    busy_d  = (state_d == COLLECT) && (cnt_d != CNT_ZERO);
  end

  assign parallelOutput = shift_q;
  assign wordValid      = valid_q;
  assign busy           = busy_q;
  assign bitCount       = cnt_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector: directed scenarios plus random
// traffic, checked against a queue-based behavioural model.
module tb_serial_word_collector;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = $clog2(W) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic             serialInput;
  logic             bitValid;
  logic             LoR;
  logic             wordReady;
  logic [W-1:0]     parallelOutput;
  logic             wordValid;
  logic             busy;
  logic [CNT_W-1:0] bitCount;
  logic             overflow;

  serial_word_collector #(.WORD_LENGTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .serialInput    (serialInput),
    .bitValid       (bitValid),
    .LoR            (LoR),
    .wordReady      (wordReady),
    .parallelOutput (parallelOutput),
    .wordValid      (wordValid),
    .busy           (busy),
    .bitCount       (bitCount),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: bits of the current word in arrival order, plus held-word flags.
  bit          m_bits[$];
  bit          m_dir;
  bit          m_full;
  bit          m_ovf;
  logic [31:0] m_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] assemble(input bit dir);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < int'(W); i++) begin
      if (dir) w = w | (32'(m_bits[i]) << i);
      else     w = (w << 1) | 32'(m_bits[i]);
    end
    return w;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_dir  = 1'b0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_word = 32'h0;
  endtask

  task automatic model_step(input bit bv, input bit b, input bit lor, input bit rdy, input bit clr);
    if (clr) begin
      m_bits.delete();
      m_full = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_full) begin
      if (rdy) begin
        m_full = 1'b0;
        m_bits.delete();
        if (bv) begin
          m_dir = lor;
          m_bits.push_back(b);
        end
      end else if (bv) begin
        m_ovf = 1'b1;
      end
    end else if (bv) begin
      if (m_bits.size() == 0) m_dir = lor;
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        m_full = 1'b1;
        m_word = assemble(m_dir);
      end
    end
  endtask

  task automatic compare_all();
    int exp_cnt = m_full ? int'(W) : m_bits.size();
    check("wordValid", 32'(wordValid), 32'(m_full));
    check("bitCount", 32'(bitCount), 32'(exp_cnt));
    check("busy", 32'(busy), 32'(!m_full && m_bits.size() != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_full) check("parallelOutput", 32'(parallelOutput), m_word);
  endtask

  // One clock: apply inputs, advance the model at the edge, then compare.
  task automatic cyc(input bit bv, input bit b, input bit lor, input bit rdy, input bit clr);
    bitValid    = bv;
    serialInput = b;
    LoR         = lor;
    wordReady   = rdy;
    clear       = clr;
    @(posedge clk);
    model_step(bv, b, lor, rdy, clr);
    #1;
    compare_all();
  endtask

  // Sends the 8 bits of seq, seq[7] first; optional LoR scrambling after bit 0
  // and random idle gaps between bits. Checks the resulting word against expect.
  task automatic send_seq(input logic [7:0] seq, input bit lor, input bit scramble,
                          input bit rdy, input int gap_max, input logic [7:0] expect_w);
    for (int i = 0; i < 8; i++) begin
      bit l = (i != 0 && scramble) ? 1'($urandom_range(0, 1)) : lor;
      if (i != 0 && gap_max > 0) begin
        int g = $urandom_range(1, gap_max);
        for (int k = 0; k < g; k++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy, 1'b0);
      end
      cyc(1'b1, seq[7-i], l, rdy, 1'b0);
    end
    check("word_value", 32'(parallelOutput), 32'(expect_w));
    check("word_valid", 32'(wordValid), 32'h1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {16'h0, 8'(parallelOutput), 4'(bitCount), 1'b0, wordValid, busy, overflow}, 32'h0);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; serialInput = 1'b0; bitValid = 1'b0;
    LoR = 1'b0; wordReady = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset_state");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    compare_all();

    // MSB-first and LSB-first (with LoR scrambled after the first bit)
    send_seq(8'hB2, 1'b0, 1'b0, 1'b1, 0, 8'hB2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_seq(8'hB2, 1'b1, 1'b1, 1'b1, 0, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back words with no idle cycle
    send_seq(8'hB2, 1'b0, 1'b0, 1'b1, 0, 8'hB2);
    send_seq(8'h5A, 1'b0, 1'b0, 1'b1, 0, 8'h5A);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b_overflow", 32'(overflow), 32'h0);

    // Backpressure: extra bits while held set overflow and are dropped
    send_seq(8'hB2, 1'b0, 1'b0, 1'b0, 0, 8'hB2);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_overflow", 32'(overflow), 32'h1);
    check("bp_word_held", 32'(parallelOutput), 32'hB2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_accepted", 32'(wordValid), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clear_outputs", {8'(parallelOutput), 4'(bitCount), 3'b0, overflow}, 32'h0);

    // Gapped input
    send_seq(8'h3C, 1'b0, 1'b0, 1'b1, 3, 8'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-word, asserted between edges
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    bitValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_reset_mid_word");
    @(posedge clk);
    #1 reset = 1'b1;
    compare_all();
    send_seq(8'hA5, 1'b0, 1'b0, 1'b1, 0, 8'hA5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear mid-word with a simultaneous bit: that bit is dropped
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("clear_drops_bit", 32'(bitCount), 32'h0);
    send_seq(8'hA5, 1'b0, 1'b0, 1'b1, 0, 8'hA5);

    // Random traffic: valid density, backpressure, direction and rare clears
    for (int n = 0; n < 1500; n++) begin
      cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 99) < 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Serial-in, parallel-out word assembler for the sequential multiplier datapath. It is the receiving end of the shift-register serial link: it takes one bit per qualified cycle, MSB-first or LSB-first, and builds a WORD_LENGTH-bit word. It then presents the word to a downstream consumer through a valid/ready handshake. Bit counting, per-word direction latching, zero-bubble back-to-back reception and a sticky overflow flag are all handled inside the block.

## Interface
- WORD_LENGTH, 8: bits per assembled word (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous clear; aborts the current word and clears overflow
- serialInput  input  1  incoming data bit
- bitValid  input  1  serialInput is valid this cycle
- LoR  input  1  0 = MSB-first (shift left, new bit enters at [0]); 1 = LSB-first (shift right, new bit enters at [WORD_LENGTH-1]); sampled on the first bit of each word only
- wordReady  input  1  consumer accepts the word this cycle
- parallelOutput  output  WORD_LENGTH  assembled word; stable while wordValid=1
- wordValid  output  1  a complete word is held
- busy  output  1  partial word in progress (COLLECT with bitCount≠0)
- bitCount  output  $clog2(WORD_LENGTH)+1  bits received in the current word; reads WORD_LENGTH in FULL
- overflow  output  1  sticky: a bit arrived while FULL and the word was not accepted

## Operation
- States: COLLECT and FULL. Reset and clear both force COLLECT.
- COLLECT, bitValid=1, bitCount=0:
  - latch LoR into dirLatched
  - load the register with the bit in its entry position and all other bits zero
  - bitCount←1
- COLLECT, bitValid=1, 0<bitCount<WORD_LENGTH-1:
  - shift per dirLatched: left = {reg[W-2:0], bit}; right = {bit, reg[W-1:1]}
  - bitCount+1
- COLLECT, bitValid=1, bitCount=WORD_LENGTH-1:
  - final shift
  - bitCount←WORD_LENGTH
  - go to FULL
- COLLECT, bitValid=0: hold everything.
- FULL:
  - wordValid=1; parallelOutput frozen.
  - wordValid & wordReady, bitValid=0: go to COLLECT, bitCount←0. Register contents hold; they are not visible because wordValid=0.
  - wordValid & wordReady, bitValid=1 (zero-bubble): the bit is the first bit of the next word. LoR is latched, the register is loaded as above, bitCount←1, go to COLLECT.
  - wordReady=0, bitValid=1: bit dropped, overflow←1, word and state unchanged.
- LoR changes while bitCount≠0 have no effect on the current word.
- clear=1: register←0, bitCount←0, overflow←0, go to COLLECT. clear takes priority over bitValid and wordReady; a bit in the same cycle is dropped.
- overflow is cleared only by clear or reset.

## Timing
- Reset values: parallelOutput=0, wordValid=0, busy=0, bitCount=0, overflow=0, state COLLECT, dirLatched=0.
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: wordValid rises on the clock edge that captures the WORD_LENGTH-th bit, so it is visible the cycle after that bit is presented.
- Handshake: transfer occurs on an edge where wordValid=1 and wordReady=1; wordValid falls on that same edge unless FULL is re-entered. The consumer may hold wordReady high permanently.
- Sustained throughput: one bit per cycle with wordReady=1 loses no bits; wordValid pulses one cycle per word.
- Asynchronous reset mid-word discards the partial word immediately; the first bitValid after reset release is bit 0 of a new word.
- busy falls on the same edge wordValid rises.

## Test plan
- MSB-first: LoR=0, bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles, wordReady=1 → wordValid=1 one cycle after the 8th bit, parallelOutput=8'hB2, bitCount=8; busy high for cycles 2–8.
- LSB-first: LoR=1, same bit sequence → parallelOutput=8'h4D. Toggling LoR after bit 1 does not change the result.
- Back-to-back: 16 continuous bits (0xB2 then 0x5A, MSB-first), wordReady=1 → two single-cycle wordValid pulses 8 cycles apart carrying 8'hB2 and 8'h5A; no bit lost, overflow=0.
- Backpressure/overflow: hold wordReady=0 after 0xB2 completes, then drive 3 more bits → overflow=1, parallelOutput stays 8'hB2, wordValid stays 1. Assert wordReady → accepted. Assert clear → overflow=0, bitCount=0.
- Gapped input: 8 bits of 0x3C with bitValid=0 gaps of 1–3 cycles between them → parallelOutput=8'h3C; bitCount holds during gaps.
- Reset/clear mid-word: after 5 bits assert reset (async, between edges) → all outputs 0 immediately. Then send 8 bits of 0xA5 → 8'hA5. Repeat with clear and a simultaneous bitValid → that bit is dropped.
